// File: rtl/multi_lane_serdes.sv
// multi_lane_serdes: NLANES-wide MSB-first serialiser/deserialiser with
// per-lane comma alignment (HUNT/CHECK/LOCKED) and idle-comma stripping.
// Ports:
//   i_clk, i_rst_n (async, active low)
//   i_tx_data, i_tx_valid, o_tx_ready    parallel TX side
//   o_txp, o_txn                         serial TX pairs
//   i_rxp, i_rxn                         serial RX pairs (i_rxp is used)
//   i_realign                            send all lanes back to HUNT
//   o_rx_data, o_rx_valid, o_rx_lock     parallel RX side
// Optional: define SERDES_LOOPBACK_EN to add i_loopback (RX from own TX).
module multi_lane_serdes #(
    parameter int                PWIDTH   = 20,
    parameter int                NLANES   = 4,
    parameter logic [PWIDTH-1:0] COMMA    = 20'h3E0F1,
    parameter int                LOCK_CNT = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NLANES*PWIDTH-1:0] i_tx_data,
    input  logic                     i_tx_valid,
    output logic                     o_tx_ready,
    output logic [NLANES-1:0]        o_txp,
    output logic [NLANES-1:0]        o_txn,
    input  logic [NLANES-1:0]        i_rxp,
    input  logic [NLANES-1:0]        i_rxn,
`ifdef SERDES_LOOPBACK_EN
    input  logic                     i_loopback,
`endif
    input  logic                     i_realign,
    output logic [NLANES*PWIDTH-1:0] o_rx_data,
    output logic [NLANES-1:0]        o_rx_valid,
    output logic [NLANES-1:0]        o_rx_lock
);

    localparam int             CW      = $clog2(PWIDTH);
    localparam logic [CW-1:0]  CNT_MAX = CW'(PWIDTH - 1);
    localparam logic [3:0]     LC4     = 4'(LOCK_CNT);

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        LOCKED
    } state_t;

    // The negative leg carries no extra information.
    logic rxn_unused;
    assign rxn_unused = ^i_rxn;

    logic [CW-1:0] tx_cnt;

    assign o_tx_ready = (tx_cnt == CNT_MAX);
    assign o_txn      = ~o_txp;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_cnt <= '0;
        end else if (o_tx_ready) begin
            tx_cnt <= '0;
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < NLANES; k++) begin : g_lane
        logic [PWIDTH-1:0] tx_sr;
        logic [PWIDTH-1:0] rx_sr;
        logic              rx_bit;
        logic [CW-1:0]     cnt_q, cnt_d;
        logic [3:0]        good_q, good_d;
        state_t            state_q, state_d;
        logic [PWIDTH-1:0] data_q, data_d;
        logic              valid_q, valid_d;
        logic              is_comma;
        logic              boundary;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                tx_sr <= '0;
            end else if (o_tx_ready) begin
                tx_sr <= i_tx_valid ? i_tx_data[k*PWIDTH +: PWIDTH]
                                    : COMMA;
            end else begin
                tx_sr <= {tx_sr[PWIDTH-2:0], 1'b0};
            end
        end

        assign o_txp[k] = tx_sr[PWIDTH-1];

`ifdef SERDES_LOOPBACK_EN
        // Loopback taps the TX MSB directly: no extra latency.
        assign rx_bit = i_loopback ? tx_sr[PWIDTH-1] : i_rxp[k];
`else
        assign rx_bit = i_rxp[k];
`endif

        assign is_comma = (rx_sr == COMMA);
        assign boundary = (cnt_q == CNT_MAX);

        always_comb begin
            state_d = state_q;
            good_d  = good_q;
            cnt_d   = boundary ? '0 : cnt_q + 1'b1;
            data_d  = data_q;
            valid_d = 1'b0;
            if (i_realign) begin
                state_d = HUNT;
                good_d  = '0;
            end else begin
                unique case (state_q)
                    HUNT: begin
                        // Restart the phase so the comma ends a word
                        // here; next boundary is PWIDTH edges later.
                        if (is_comma) begin
                            cnt_d   = '0;
                            good_d  = 4'd1;
                            state_d = (LOCK_CNT == 1) ? LOCKED : CHECK;
                        end
                    end
                    CHECK: begin
                        if (boundary) begin
                            if (is_comma) begin
                                good_d = good_q + 4'd1;
                                if (good_d == LC4) begin
                                    state_d = LOCKED;
                                end
                            end else begin
                                good_d  = '0;
                                state_d = HUNT;
                            end
                        end
                    end
                    LOCKED: begin
                        if (boundary && !is_comma) begin
                            data_d  = rx_sr;
                            valid_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d = HUNT;
                        good_d  = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                rx_sr   <= '0;
                cnt_q   <= '0;
                good_q  <= '0;
                state_q <= HUNT;
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                rx_sr   <= {rx_sr[PWIDTH-2:0], rx_bit};
                cnt_q   <= cnt_d;
                good_q  <= good_d;
                state_q <= state_d;
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign o_rx_data[k*PWIDTH +: PWIDTH] = data_q;
        assign o_rx_valid[k]                 = valid_q;
        assign o_rx_lock[k]                  = (state_q == LOCKED);
    end

endmodule

// File: tb/tb_multi_lane_serdes.sv
// tb_multi_lane_serdes: directed vector table plus hand-written sequences
// for multi_lane_serdes (loopback, bit offset, realign, reset mid-word).
module tb_multi_lane_serdes;

    localparam int         W  = 20;
    localparam int         NL = 4;
    localparam int         NV = 7;
    localparam logic [W-1:0] CM = 20'h3E0F1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [NL*W-1:0] tx_data = '0;
    logic            tx_valid = 1'b0;
    logic            tx_ready;
    logic [NL-1:0]   txp, txn;
    logic [NL-1:0]   rxp, rxn;
    logic [NL-1:0]   rxp_drv = '0;
    logic            lb = 1'b1;
    logic            realign = 1'b0;
    logic [NL*W-1:0] rx_data;
    logic [NL-1:0]   rx_valid, rx_lock;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

`ifdef SERDES_LOOPBACK_EN
    // Pins carry garbage; the DUT must use its internal path.
    assign rxp = lb ? ~txp : rxp_drv;
`else
    assign rxp = lb ? txp : rxp_drv;
`endif
    assign rxn = ~rxp;

    multi_lane_serdes dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_tx_data  (tx_data),
        .i_tx_valid (tx_valid),
        .o_tx_ready (tx_ready),
        .o_txp      (txp),
        .o_txn      (txn),
        .i_rxp      (rxp),
        .i_rxn      (rxn),
`ifdef SERDES_LOOPBACK_EN
        .i_loopback (lb),
`endif
        .i_realign  (realign),
        .o_rx_data  (rx_data),
        .o_rx_valid (rx_valid),
        .o_rx_lock  (rx_lock)
    );

    typedef struct {
        logic [W-1:0]  base;
        logic          add_lane;
        logic          vld;
        logic [NL-1:0] exp_v;
    } vec_t;

    vec_t         vecs[NV];
    logic [W-1:0] held[NL];
    logic         strm[NL][512];
    int           s_lock[NL];
    int           s_vc[NL];
    logic [W-1:0] s_data[NL];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!tx_ready && n < 40) begin
            tick();
            n++;
        end
        chk("tx_ready_wait", tx_ready, 1);
    endtask

    function automatic logic [W-1:0] lane_word(vec_t v, int k);
        return v.add_lane ? v.base + W'(k) : v.base;
    endfunction

    task automatic clr_strm();
        for (int l = 0; l < NL; l++)
            for (int i = 0; i < 512; i++)
                strm[l][i] = 1'b0;
    endtask

    task automatic put(input int l, input int pos, input logic [W-1:0] w);
        for (int b = 0; b < W; b++)
            strm[l][pos+b] = w[W-1-b];
    endtask

    // Bit i is driven after an edge and sampled by the next one (edge i+1).
    task automatic run_strm(input int n);
        for (int l = 0; l < NL; l++) begin
            s_lock[l] = -1;
            s_vc[l]   = 0;
            s_data[l] = '0;
        end
        for (int i = 0; i < n; i++) begin
            for (int l = 0; l < NL; l++) rxp_drv[l] = strm[l][i];
            tick();
            for (int l = 0; l < NL; l++) begin
                if (rx_valid[l]) begin
                    s_vc[l]++;
                    s_data[l] = rx_data[l*W +: W];
                end
                if (rx_lock[l] && s_lock[l] < 0) s_lock[l] = i + 1;
            end
        end
        rxp_drv = '0;
    endtask

    task automatic hunt_all();
        lb = 1'b0;
        rxp_drv = '0;
        repeat (25) tick();
        realign = 1'b1;
        tick();
        realign = 1'b0;
        chk("hunt_unlock", rx_lock, 0);
    endtask

    task automatic idle_lock(input string tag);
        int ready_at = -1;
        int lock_at = -1;
        int nval = 0;
        for (int e = 1; e <= 130; e++) begin
            tick();
            if (tx_ready && ready_at < 0) ready_at = e;
            if (rx_lock == 4'hF && lock_at < 0) lock_at = e;
            nval += $countones(rx_valid);
        end
        chk({tag, "_first_ready"}, ready_at, 19);
        chk({tag, "_lock_edge"}, lock_at, 101);
        chk({tag, "_valids"}, nval, 0);
    endtask

    initial begin
        logic [NL*W-1:0] exp_rd;
        int nv;
        int lk;

        vecs[0] = '{20'h12340, 1'b1, 1'b1, 4'hF};
        vecs[1] = '{20'h00000, 1'b0, 1'b0, 4'h0};
        vecs[2] = '{CM,        1'b0, 1'b1, 4'h0};
        vecs[3] = '{20'hFFFFF, 1'b0, 1'b1, 4'hF};
        vecs[4] = '{20'h00000, 1'b0, 1'b1, 4'hF};
        vecs[5] = '{20'h3E0F0, 1'b1, 1'b1, 4'hD};
        vecs[6] = '{20'h80000, 1'b1, 1'b1, 4'hF};
        for (int k = 0; k < NL; k++) held[k] = '0;

        // Reset values
        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_txp", txp, 0);
        chk("rst_txn", txn, 4'hF);
        chk("rst_ready", tx_ready, 0);
        chk("rst_lock", rx_lock, 0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        rst_n = 1'b1;

        // Idle lock on loopback commas
        lb = 1'b1;
        idle_lock("idle");

        // Vector table: capture edge E, result after edge E+W+1
        for (int i = 0; i < NV; i++) begin
            wait_ready();
            for (int k = 0; k < NL; k++)
                tx_data[k*W +: W] = lane_word(vecs[i], k);
            tx_valid = vecs[i].vld;
            tick();
            tx_valid = 1'b0;
            tx_data = '0;
            nv = 0;
            for (int t = 1; t <= W + 1; t++) begin
                tick();
                nv += $countones(rx_valid);
                if (t == W + 1)
                    chk($sformatf("vec%0d_valid", i), rx_valid,
                        vecs[i].exp_v);
            end
            for (int k = 0; k < NL; k++) begin
                if (vecs[i].exp_v[k]) held[k] = lane_word(vecs[i], k);
                exp_rd[k*W +: W] = held[k];
            end
            chk($sformatf("vec%0d_count", i), nv,
                $countones(vecs[i].exp_v));
            chk($sformatf("vec%0d_data", i), rx_data, exp_rd);
        end

        // Realign on the very edge a valid was due: suppressed
        wait_ready();
        tx_data = {NL{20'h12345}};
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        nv = 0;
        repeat (W) begin
            tick();
            nv += $countones(rx_valid);
        end
        realign = 1'b1;
        tick();
        realign = 1'b0;
        chk("realign_valid", rx_valid, 0);
        chk("realign_lock", rx_lock, 0);
        lk = -1;
        for (int e = 1; e <= 122; e++) begin
            tick();
            nv += $countones(rx_valid);
            if (rx_lock == 4'hF && lk < 0) lk = e;
        end
        chk("relock_edge", lk, 80);
        chk("realign_nvalid", nv, 0);

        // Bit offset on external RX, lanes independent
        hunt_all();
        clr_strm();
        for (int j = 0; j < 5; j++) put(0, 7 + 20*j, CM);
        put(0, 107, 20'hABCDE);
        put(0, 127, CM);
        put(0, 147, CM);
        for (int j = 0; j < 4; j++) put(1, 13 + 20*j, CM);
        put(1, 93, 20'h55555);
        for (int j = 0; j < 3; j++) put(1, 113 + 20*j, CM);
        for (int j = 0; j < 3; j++) put(2, 20*j, CM);
        run_strm(185);
        chk("ofs_lock0", s_lock[0], 88);
        chk("ofs_vc0", s_vc[0], 1);
        chk("ofs_data0", s_data[0], 20'hABCDE);
        chk("ofs_lock1", s_lock[1], 94);
        chk("ofs_vc1", s_vc[1], 1);
        chk("ofs_data1", s_data[1], 20'h55555);
        chk("ofs_lock2", s_lock[2], -1);
        chk("ofs_lock3", s_lock[3], -1);
        chk("ofs_vc23", s_vc[2] + s_vc[3], 0);
        chk("ofs_hold0", rx_data[0 +: W], 20'hABCDE);

        // Corrupt word during CHECK restarts the lock count
        hunt_all();
        clr_strm();
        put(0, 0, CM);
        put(0, 20, CM);
        for (int j = 0; j < 4; j++) put(0, 60 + 20*j, CM);
        put(0, 140, 20'h0BEEF);
        put(0, 160, CM);
        for (int j = 0; j < 10; j++) put(1, 20*j, CM);
        for (int j = 0; j < 3; j++) put(2, 20*j, CM);
        put(2, 60, 20'h3E0F0);
        for (int j = 0; j < 6; j++) put(2, 80 + 20*j, CM);
        run_strm(195);
        chk("cor_lock0", s_lock[0], 141);
        chk("cor_vc0", s_vc[0], 1);
        chk("cor_data0", s_data[0], 20'h0BEEF);
        chk("cor_lock1", s_lock[1], 81);
        chk("cor_vc1", s_vc[1], 0);
        chk("cor_lock2", s_lock[2], 161);
        chk("cor_vc2", s_vc[2], 0);
        chk("cor_lock3", s_lock[3], -1);

        // Async reset half-way through a TX word
        lb = 1'b1;
        wait_ready();
        tx_data = {NL{20'h13579}};
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_txp", txp, 0);
        chk("mid_rst_txn", txn, 4'hF);
        chk("mid_rst_ready", tx_ready, 0);
        chk("mid_rst_valid", rx_valid, 0);
        chk("mid_rst_lock", rx_lock, 0);
        chk("mid_rst_data", rx_data, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        idle_lock("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_lane_serdes.md
# multi_lane_serdes

Parametrised multi-lane successor to the single-lane serdes model. It serialises NLANES parallel words per lane onto differential outputs MSB-first, and deserialises NLANES differential inputs back to words. Each RX lane has its own comma-based word-alignment state machine, and idle comma fill is stripped. It runs entirely on the serial bit clock, with parallel-side transfers qualified by strobes, and sits between the link-layer mux and the pad/PHY model.

## Interface
Parameters:
- PWIDTH, 20, bits per parallel word per lane (≥ 8).
- NLANES, 4, number of independent lanes (≥ 1).
- COMMA, 20'h3E0F1, PWIDTH-bit alignment/idle word.
- LOCK_CNT, 4, consecutive aligned commas required to declare lock (1..15).

Ports:
- i_clk  in  1  serial bit clock; all logic on its rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_tx_data  in  NLANES*PWIDTH  TX words; lane k is bits [k*PWIDTH +: PWIDTH].
- i_tx_valid  in  1  TX words present; sampled only when o_tx_ready=1.
- o_tx_ready  out  1  one-cycle strobe: TX words are captured this cycle.
- o_txp / o_txn  out  NLANES  serial TX pair per lane; o_txn = ~o_txp.
- i_rxp / i_rxn  in  NLANES  serial RX pair per lane; received bit is i_rxp.
- i_realign  in  1  synchronous pulse: all lanes return to HUNT.
- o_rx_data  out  NLANES*PWIDTH  RX words, held between valids.
- o_rx_valid  out  NLANES  per-lane one-cycle strobe for a new non-comma word.
- o_rx_lock  out  NLANES  per-lane alignment-locked flag.

## Operation
TX path:
- A shared counter tx_cnt runs 0..PWIDTH-1 and wraps; it is 0 in reset and first increments on the first edge after release.
- o_tx_ready = (tx_cnt == PWIDTH-1).
- On that edge each lane shift register loads i_tx_data[lane] if i_tx_valid=1, else COMMA. Otherwise it shifts left, filling with 0.
- o_txp[lane] = shift[PWIDTH-1].

RX path, per lane:
- A PWIDTH-bit shift register takes the received bit into the LSB each edge.
- A phase counter rx_cnt (0..PWIDTH-1) marks the word boundary.
- Alignment FSM states are HUNT, CHECK and LOCKED; the reset state is HUNT.
- HUNT: compares every cycle. When the shift register equals COMMA, rx_cnt is forced so that this cycle is a boundary, good_cnt is set to 1, and the FSM goes to CHECK. If LOCK_CNT = 1, it goes directly to LOCKED.
- CHECK: at each boundary, a word equal to COMMA increments good_cnt, and reaching LOCK_CNT moves the FSM to LOCKED. Any non-comma word returns the FSM to HUNT.
- LOCKED: at each boundary, a non-comma word is registered to o_rx_data[lane] with o_rx_valid[lane]=1. Comma words are discarded with no valid. The lane stays LOCKED until reset or i_realign.
- o_rx_lock[lane] = (state == LOCKED), registered.
- i_realign has priority over all transitions: state goes to HUNT, good_cnt to 0, and o_rx_lock drops on the next edge. Any pending valid for that cycle is suppressed.

Reset (async assert, all outputs):
- o_tx_ready=0, o_txp=0, o_txn=all-1.
- o_rx_data=0, o_rx_valid=0, o_rx_lock=0.
- All counters 0, all FSMs in HUNT.
- Reset mid-word abandons the word; no partial word is ever output.

## Timing
- TX word captured at edge E (o_tx_ready high before E). Its MSB drives o_txp from just after E, and its LSB from just after E+PWIDTH-1.
- RX: the last bit of a word is sampled at edge S. o_rx_data and o_rx_valid update at edge S+1, so valid is high for the cycle S+1..S+2.
- Lanes are aligned independently; no inter-lane deskew is performed.
- o_rx_valid spacing on a locked lane is a multiple of PWIDTH cycles.

## Configuration
- Macro SERDES_LOOPBACK_EN.
- Defined: adds input port i_loopback (1 bit).
  - When 1, each lane's received bit is its own o_txp, taken internally with no added register. i_rxp/i_rxn are ignored.
  - o_txp/o_txn keep toggling normally.
  - When 0, reception is from the pins.
- Undefined: no i_loopback port; RX always comes from i_rxp.

## Test plan
- Reset: hold i_rst_n=0 → o_txp=0, o_txn=all-1, o_rx_lock=0, o_rx_valid=0, o_tx_ready=0. Release → first o_tx_ready at cycle PWIDTH after release (tx_cnt reaches 19).
- Idle lock (loopback, i_tx_valid=0): every lane's o_rx_lock rises within (LOCK_CNT+2)*PWIDTH+2 cycles, with no o_rx_valid pulses.
- Data after lock (loopback): present lane k = 20'h12340+k with i_tx_valid=1 for one strobe → exactly one o_rx_valid per lane, and o_rx_data lane k = 20'h12340+k, PWIDTH+1 cycles after the capture edge.
- Bit offset (external RX): drive lane 0 with a comma stream delayed 7 bits, then word 20'hABCDE → lane 0 locks and outputs 20'hABCDE. Other lanes, driven independently, are unaffected.
- Realign and corrupt CHECK: pulse i_realign while locked → o_rx_lock=0 next edge, then re-lock on commas. A non-comma word during CHECK → back to HUNT, and lock is delayed by a full LOCK_CNT commas.
- Async reset mid-word: assert i_rst_n=0 half-way through a TX word → outputs return to reset values immediately and no o_rx_valid is produced for the truncated word.
